// File: rtl/vga_fml_linefetch.sv
// Double-buffered scan-line fetcher: reads the next line from FML memory in 4-word
// bursts during horizontal blanking and serves the displayed line to the CRTC.
module vga_fml_linefetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_crtc,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        video_on_h_i,
  input  logic        video_on_v,
  input  logic        horiz_sync_i,
  input  logic        vert_sync,
  input  logic [9:0]  vert_total,
  input  logic [9:0]  end_vert,
  input  logic [16:0] start_addr,
  input  logic [7:0]  offset,
  input  logic [4:0]  bursts_per_line,
  output logic [19:0] fml_adr,
  output logic        fml_stb,
  output logic        fml_we,
  input  logic        fml_ack,
  input  logic [15:0] fml_di,
  output logic [15:0] pix_word,
  output logic        video_on,
  output logic        horiz_sync,
  output logic        vert_sync_o,
  output logic        underrun
);

  typedef enum logic [1:0] {IDLE, REQ, BEAT} state_t;

  state_t      state;
  logic [15:0] lbuf [0:255];  // {bank, word}
  logic        prev_von_h;
  logic        front_sel;
  logic        fill_bank;
  logic [16:0] adr;
  logic [16:0] ptr;
  logic [6:0]  wcnt;
  logic [1:0]  beat;
  logic [4:0]  bursts_left;

  logic        trigger, swap, fetch_start, beat_wr;
  logic [9:0]  last_line, nv;
  logic [16:0] fa;
  logic        unused_h;

  assign unused_h    = ^h_count[2:0];
  assign fml_we      = 1'b0;
  assign fml_adr     = {adr, 3'b000};

  assign trigger     = enable_crtc & prev_von_h & ~video_on_h_i;
  assign swap        = enable_crtc & ~prev_von_h & video_on_h_i;
  assign last_line   = 10'(vert_total + 10'd1);
  assign nv          = (v_count == last_line) ? 10'd0 : 10'(v_count + 10'd1);
  assign fetch_start = trigger && (nv <= end_vert) && (bursts_per_line != 5'd0) && (state == IDLE);
  assign fa          = (nv == 10'd0) ? start_addr : ptr;
  assign beat_wr     = ((state == REQ) && fml_ack) || (state == BEAT);

  // Display side: advances only on pixel-rate cycles so outputs stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_von_h  <= 1'b0;
      front_sel   <= 1'b0;
      underrun    <= 1'b0;
      pix_word    <= '0;
      video_on    <= 1'b0;
      horiz_sync  <= 1'b1;
      vert_sync_o <= 1'b1;
    end else if (enable_crtc) begin
      prev_von_h  <= video_on_h_i;
      pix_word    <= lbuf[{front_sel, h_count[9:3]}];
      video_on    <= video_on_h_i & video_on_v;
      horiz_sync  <= horiz_sync_i;
      vert_sync_o <= vert_sync;
      if (swap) begin
        front_sel <= ~front_sel;
        if (state != IDLE) underrun <= 1'b1;
      end
    end
  end

  // Fetch side runs at full clock rate; fill_bank is latched so a late fetch
  // still lands in the bank it started on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fml_stb     <= 1'b0;
      adr         <= '0;
      ptr         <= '0;
      wcnt        <= '0;
      beat        <= '0;
      bursts_left <= '0;
      fill_bank   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (fetch_start) begin
          state       <= REQ;
          fml_stb     <= 1'b1;
          adr         <= fa;
          ptr         <= fa + 17'(offset);
          wcnt        <= '0;
          bursts_left <= bursts_per_line;
          fill_bank   <= ~front_sel;
        end
        REQ: if (fml_ack) begin
          state   <= BEAT;
          fml_stb <= 1'b0;
          beat    <= 2'd1;
          wcnt    <= wcnt + 7'd1;
        end
        BEAT: begin
          wcnt <= wcnt + 7'd1;
          if (beat == 2'd3) begin
            bursts_left <= bursts_left - 5'd1;
            if (bursts_left > 5'd1) begin
              state   <= REQ;
              fml_stb <= 1'b1;
              adr     <= adr + 17'd1;
            end else begin
              state <= IDLE;
            end
          end else begin
            beat <= beat + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr) lbuf[{fill_bank, wcnt}] <= fml_di;
  end

endmodule

// File: tb/tb_vga_fml_linefetch.sv
// Bench for vga_fml_linefetch: acts as the FML slave and CRTC, and keeps a
// line-level model of both line buffer banks, the stride pointer and the error flag.
module tb_vga_fml_linefetch;
  logic clk = 1'b0;
  logic rst;
  logic enable_crtc;
  logic [9:0] h_count, v_count, vert_total, end_vert;
  logic video_on_h_i, video_on_v, horiz_sync_i, vert_sync;
  logic [16:0] start_addr;
  logic [7:0] offset;
  logic [4:0] bursts_per_line;
  logic [19:0] fml_adr;
  logic fml_stb, fml_we, fml_ack;
  logic [15:0] fml_di, pix_word;
  logic video_on, horiz_sync, vert_sync_o, underrun;

  always #5 clk = ~clk;

  vga_fml_linefetch dut (
    .clk(clk), .rst(rst), .enable_crtc(enable_crtc), .h_count(h_count), .v_count(v_count),
    .video_on_h_i(video_on_h_i), .video_on_v(video_on_v), .horiz_sync_i(horiz_sync_i),
    .vert_sync(vert_sync), .vert_total(vert_total), .end_vert(end_vert),
    .start_addr(start_addr), .offset(offset), .bursts_per_line(bursts_per_line),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_ack(fml_ack), .fml_di(fml_di),
    .pix_word(pix_word), .video_on(video_on), .horiz_sync(horiz_sync),
    .vert_sync_o(vert_sync_o), .underrun(underrun)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] mbuf [0:255];
  bit          mval [0:255];
  bit          m_front, m_fill, m_prev, m_busy, m_under;
  logic [16:0] m_ptr;
  int          m_wcnt;

  typedef struct {
    logic [9:0]  h;
    logic        en, vv, hs, vs;
    logic [15:0] pix;
    logic        von, ehs, evs;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_front = 0; m_prev = 0; m_busy = 0; m_under = 0; m_ptr = '0; m_wcnt = 0;
  endtask

  task automatic model_write(input logic [15:0] d);
    mbuf[{m_fill, 7'(m_wcnt)}] = d;
    mval[{m_fill, 7'(m_wcnt)}] = 1;
    m_wcnt++;
  endtask

  // End of active line at scan line vc; reports whether a fetch should start.
  task automatic line_end(input logic [9:0] vc, output bit started, output logic [16:0] base);
    logic [9:0] nv;
    v_count = vc; enable_crtc = 1; video_on_h_i = 0;
    step();
    enable_crtc = 0;
    nv = (vc == 10'(vert_total + 10'd1)) ? 10'd0 : 10'(vc + 10'd1);
    started = (nv <= end_vert) && (bursts_per_line != 0) && !m_busy;
    base = (nv == 0) ? start_addr : m_ptr;
    if (started) begin
      m_ptr = base + 17'(offset);
      m_busy = 1; m_fill = ~m_front; m_wcnt = 0;
    end
    m_prev = 0;
  endtask

  task automatic line_start();
    enable_crtc = 1; video_on_h_i = 1;
    step();
    enable_crtc = 0;
    if (m_busy) m_under = 1;
    m_front = ~m_front;
    m_prev = 1;
  endtask

  task automatic wait_stb(output bit ok);
    int n = 0;
    while (!fml_stb && n < 30) begin step(); n++; end
    ok = fml_stb;
    if (!ok) chk("stb_timeout", 0, 1);
  endtask

  task automatic serve_burst(input logic [16:0] badr, input int dly, input logic [15:0] d0);
    bit ok;
    wait_stb(ok);
    if (!ok) return;
    chk("burst_adr", 32'(fml_adr), 32'({badr, 3'b000}));
    for (int i = 0; i < dly; i++) begin
      step();
      chk("stb_hold", 32'(fml_stb), 1);
      chk("adr_hold", 32'(fml_adr), 32'({badr, 3'b000}));
    end
    fml_ack = 1; fml_di = d0;
    step();
    model_write(d0);
    fml_ack = 0;
    chk("stb_drop", 32'(fml_stb), 0);
    for (int b = 1; b < 4; b++) begin
      fml_di = d0 + 16'(b);
      step();
      model_write(fml_di);
    end
  endtask

  task automatic serve_line(input logic [16:0] base, input int n, input int dly, input bit rnd_data,
                            input logic [15:0] dstart);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd_data ? 16'($urandom) : dstart + 16'(4 * i);
      serve_burst(base + 17'(i), (dly < 0) ? int'($urandom_range(0, 4)) : dly, d);
    end
    m_busy = 0;
    step();
    chk("idle_stb", 32'(fml_stb), 0);
  endtask

  task automatic disp(input logic [9:0] h);
    logic [7:0] idx;
    enable_crtc = 1; h_count = h; video_on_h_i = 1;
    step();
    enable_crtc = 0;
    idx = {m_front, h[9:3]};
    if (mval[idx]) chk("pix_word", 32'(pix_word), 32'(mbuf[idx]));
  endtask

  initial begin
    bit          st, ok;
    logic [16:0] base;
    logic [15:0] epix;
    bit          epv;
    logic        evon, ehs, evs;
    logic [7:0]  idx;

    tbl[0] = '{h:10'd0,   en:1, vv:1, hs:1, vs:1, pix:16'd0,  von:1, ehs:1, evs:1};
    tbl[1] = '{h:10'd8,   en:1, vv:1, hs:0, vs:1, pix:16'd1,  von:1, ehs:0, evs:1};
    tbl[2] = '{h:10'd45,  en:1, vv:0, hs:1, vs:0, pix:16'd5,  von:0, ehs:1, evs:0};
    tbl[3] = '{h:10'd100, en:0, vv:1, hs:0, vs:1, pix:16'd5,  von:0, ehs:1, evs:0};
    tbl[4] = '{h:10'd100, en:1, vv:1, hs:1, vs:1, pix:16'd12, von:1, ehs:1, evs:1};
    tbl[5] = '{h:10'd319, en:1, vv:1, hs:1, vs:0, pix:16'd39, von:1, ehs:1, evs:0};
    tbl[6] = '{h:10'd632, en:1, vv:1, hs:0, vs:0, pix:16'd79, von:1, ehs:0, evs:0};
    tbl[7] = '{h:10'd504, en:0, vv:0, hs:1, vs:1, pix:16'd79, von:1, ehs:0, evs:0};
    tbl[8] = '{h:10'd511, en:1, vv:1, hs:1, vs:1, pix:16'd63, von:1, ehs:1, evs:1};

    for (int i = 0; i < 256; i++) mval[i] = 0;
    rst = 1; enable_crtc = 0; h_count = 0; v_count = 0;
    video_on_h_i = 0; video_on_v = 1; horiz_sync_i = 1; vert_sync = 1;
    vert_total = 10'd524; end_vert = 10'd479;
    start_addr = 17'h100; offset = 8'd10; bursts_per_line = 5'd20;
    fml_ack = 0; fml_di = 0;
    model_reset();
    step(); step();
    chk("rst_stb", 32'(fml_stb), 0);
    chk("rst_adr", 32'(fml_adr), 0);
    chk("rst_we", 32'(fml_we), 0);
    chk("rst_pix", 32'(pix_word), 0);
    chk("rst_von", 32'(video_on), 0);
    chk("rst_hs", 32'(horiz_sync), 1);
    chk("rst_vs", 32'(vert_sync_o), 1);
    chk("rst_under", 32'(underrun), 0);
    rst = 0;
    step();

    // frame-start fetch: 20 bursts from 0x100, 5-cycle ack latency, data 0..79
    line_start();
    line_end(10'd525, st, base);
    chk("fs_started", 32'(st), 1);
    chk("fs_base", 32'(base), 32'h100);
    serve_line(base, 20, 5, 0, 16'd0);
    chk("fs_last_adr", 32'(fml_adr), 32'h00898);
    line_start();
    for (int i = 0; i < 9; i++) begin
      enable_crtc = tbl[i].en; h_count = tbl[i].h; video_on_h_i = 1;
      video_on_v = tbl[i].vv; horiz_sync_i = tbl[i].hs; vert_sync = tbl[i].vs;
      step();
      chk("tbl_pix", 32'(pix_word), 32'(tbl[i].pix));
      chk("tbl_von", 32'(video_on), 32'(tbl[i].von));
      chk("tbl_hs", 32'(horiz_sync), 32'(tbl[i].ehs));
      chk("tbl_vs", 32'(vert_sync_o), 32'(tbl[i].evs));
    end
    enable_crtc = 0; video_on_v = 1; horiz_sync_i = 1; vert_sync = 1;

    // second line uses the advanced pointer 0x10A
    line_end(10'd0, st, base);
    chk("l1_started", 32'(st), 1);
    wait_stb(ok);
    chk("l1_adr", 32'(fml_adr), 32'h00850);
    serve_line(base, 20, -1, 1, 16'd0);
    line_start();
    for (int k = 0; k < 80; k += 13) disp(10'(8 * k + 3));

    // trigger on the last visible line: no fetch, but the swap still happens
    line_end(end_vert, st, base);
    chk("lv_nostart", 32'(st), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lv_no_stb", 32'(fml_stb), 0);
    end
    line_start();
    disp(10'd16);
    disp(10'd400);
    chk("lv_under", 32'(underrun), 0);

    // pixel enable toggling: display registers advance only on enabled cycles
    enable_crtc = 1; h_count = 0; video_on_h_i = 1;
    step();
    idx = {m_front, 7'd0};
    epix = mbuf[idx]; epv = mval[idx]; evon = 1; ehs = 1; evs = 1;
    for (int i = 0; i < 12; i++) begin
      enable_crtc = i[0];
      h_count = 10'($urandom_range(0, 79) * 8 + $urandom_range(0, 7));
      video_on_v = 1'($urandom); horiz_sync_i = 1'($urandom); vert_sync = 1'($urandom);
      step();
      if (enable_crtc) begin
        idx = {m_front, h_count[9:3]};
        epix = mbuf[idx]; epv = mval[idx];
        evon = video_on_v; ehs = horiz_sync_i; evs = vert_sync;
      end
      if (epv) chk("en_pix", 32'(pix_word), 32'(epix));
      chk("en_von", 32'(video_on), 32'(evon));
      chk("en_hs", 32'(horiz_sync), 32'(ehs));
      chk("en_vs", 32'(vert_sync_o), 32'(evs));
    end
    enable_crtc = 0; video_on_v = 1; horiz_sync_i = 1; vert_sync = 1;

    // underrun: ack withheld across the next line start
    bursts_per_line = 5'd4;
    line_end(10'd5, st, base);
    chk("ur_started", 32'(st), 1);
    serve_burst(base, 1, 16'h1000);
    serve_burst(base + 17'd1, 0, 16'h1004);
    wait_stb(ok);
    line_start();
    chk("ur_flag", 32'(underrun), 1);
    chk("ur_stb_held", 32'(fml_stb), 1);
    serve_burst(base + 17'd2, 2, 16'h1008);
    serve_burst(base + 17'd3, 0, 16'h100c);
    m_busy = 0;
    step();
    chk("ur_idle", 32'(fml_stb), 0);
    line_end(end_vert, st, base);
    line_start();
    chk("ur_sticky", 32'(underrun), 1);

    // reset in the middle of a burst, then a clean restart
    line_end(10'd10, st, base);
    wait_stb(ok);
    fml_ack = 1; fml_di = 16'hbeef;
    step();
    model_write(16'hbeef);
    fml_ack = 0; fml_di = 16'hbef0;
    step();
    model_write(16'hbef0);
    rst = 1;
    #1;
    chk("mr_stb", 32'(fml_stb), 0);
    chk("mr_under", 32'(underrun), 0);
    step();
    rst = 0;
    model_reset();
    step();
    chk("mr_idle", 32'(fml_stb), 0);
    line_start();
    line_end(10'd525, st, base);
    chk("mr_base", 32'(base), 32'h100);
    serve_line(base, 4, 1, 0, 16'h2000);
    line_start();
    disp(10'd0);
    disp(10'd15);
    disp(10'd120);

    // randomized lines against the model
    for (int it = 0; it < 8; it++) begin
      logic [9:0] vc;
      start_addr = 17'($urandom);
      offset = 8'($urandom);
      bursts_per_line = (it == 3) ? 5'd0 : 5'($urandom_range(1, 14));
      vert_total = 10'($urandom_range(10, 1000));
      end_vert = 10'($urandom_range(0, int'(vert_total)));
      case ($urandom_range(0, 2))
        0: vc = 10'(vert_total + 10'd1);
        1: vc = end_vert;
        default: vc = 10'($urandom_range(0, int'(vert_total) + 1));
      endcase
      line_end(vc, st, base);
      if (st) serve_line(base, int'(bursts_per_line), -1, 1, 16'd0);
      else begin
        repeat (4) step();
        chk("rnd_no_stb", 32'(fml_stb), 0);
      end
      line_start();
      chk("rnd_under", 32'(underrun), 0);
      for (int j = 0; j < 6; j++) disp(10'($urandom_range(0, 1023)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/vga_fml_linefetch.md
VGA_FML_LINEFETCH -- requirements
Module: vga_fml_linefetch

Interface
REQ-001 Ports (clock and reset first): clk in 1, 100 MHz system clock; rst in 1, reset, asynchronous active-high.
REQ-002 enable_crtc in 1, pixel-rate qualifier, same meaning as in the CRTC.
REQ-003 h_count in 10 and v_count in 10, CRTC counters.
REQ-004 video_on_h_i, video_on_v, horiz_sync_i, vert_sync in 1 each, CRTC timing, syncs active-low.
REQ-005 vert_total in 10, last scan line is vert_total+1; end_vert in 10, visible lines 0..end_vert.
REQ-006 start_addr in 17, frame base in 8-byte burst units; offset in 8, line stride in bursts; bursts_per_line in 5, 4-word bursts per line.
REQ-007 fml_adr out 20, byte address; fml_stb out 1; fml_we out 1, tied 0; fml_ack in 1; fml_di in 16, read data.
REQ-008 pix_word out 16, display word; video_on out 1; horiz_sync out 1; vert_sync_o out 1; underrun out 1, sticky error flag.

Function
REQ-009 Line buffer: two banks of 128x16, front (displayed) and back (being filled); front_sel register selects the front bank.
REQ-010 Display read, on every enable_crtc cycle: pix_word <= front[h_count[9:3]], one-cycle latency.
REQ-011 On the same enable_crtc cycles, video_on <= video_on_h_i & video_on_v, horiz_sync <= horiz_sync_i, vert_sync_o <= vert_sync, keeping timing aligned with pix_word.
REQ-012 When enable_crtc is low, the display-side registers hold.
REQ-013 Fetch trigger: enable_crtc high, video_on_h_i sampled 1 on the previous enable_crtc cycle and 0 now (end of active line).
REQ-014 Next-line index at the trigger: nv = (v_count == vert_total+1) ? 0 : v_count+1, 10-bit.
REQ-015 A fetch starts only if nv <= end_vert, bursts_per_line != 0, and the FSM is IDLE; otherwise the trigger is ignored.
REQ-016 Fetch base: fa = (nv==0) ? start_addr : ptr. At fetch start, ptr <= fa + offset, 17-bit, wraps modulo 2^17.
REQ-017 FSM states and transitions:
- IDLE: -> REQ on a fetch start.
- REQ: fml_stb=1, fml_adr={adr,3'b000}; hold until fml_ack=1; the ack cycle is beat 0.
- BEAT: beats 1..3 arrive on the 3 consecutive cycles after the ack, without ack; then -> REQ if bursts remain, else -> IDLE.
REQ-018 fml_stb rises the cycle after the trigger and drops the cycle after ack; fml_adr is stable while fml_stb is high.
REQ-019 Each beat writes fml_di into back[wcnt], with wcnt = 7-bit word counter reset to 0 at fetch start; burst address adr increments by 1 per burst.
REQ-020 Swap: video_on_h_i 0->1 on an enable_crtc cycle toggles front_sel. The swap happens whether or not a fetch occurred.
REQ-021 If the FSM is not IDLE at a swap, underrun <= 1; the in-progress fetch still completes into its original bank.
REQ-022 Display reads and fetch writes in the same cycle never target the same bank, except after an underrun.
REQ-023 The fetch FSM runs every clk and is not gated by enable_crtc.

Reset
REQ-024 rst (async) forces: FSM IDLE, fml_stb=0, fml_adr=0, ptr=0, wcnt=0, front_sel=0, pix_word=0, video_on=0, horiz_sync=1, vert_sync_o=1, underrun=0.
REQ-025 Line buffer contents are not reset.
REQ-026 rst during a burst abandons the burst; after release the block waits for the next trigger.

Verification
REQ-027 start_addr=0x100, offset=10, bursts_per_line=20, trigger with v_count=vert_total+1 -> 20 strobes at fml_adr 0x00800, 0x00808 .. 0x00898; ptr=0x10A afterwards.
REQ-028 fml_ack delayed 5 cycles per burst, fml_di=incrementing 0x0000.. -> back[0..79]=0..79; after the swap, pix_word for h_count=8*k equals k, one cycle later.
REQ-029 Trigger at v_count=end_vert -> no fml_stb; buffer still swaps at the next line start.
REQ-030 fml_ack withheld across a line start -> underrun=1 and stays 1; on later ack the fetch finishes its remaining bursts, then returns to IDLE.
REQ-031 rst pulsed mid-BEAT -> fml_stb=0 immediately; next trigger restarts with wcnt=0 and the correct address.
REQ-032 enable_crtc toggling every other cycle -> pix_word, video_on and syncs update only on enabled cycles; fetch timing is unaffected.
